hex_text_renderer: RTL
======================

Name: hex_text_renderer

Overview:
- Downstream consumer of the auxiliary snapshot RAM that the data manager fills once per frame.
- For each pixel position from the VGA timing generator, fetches the right 16-bit aux word and selects one hex nibble. It then looks up the glyph row in the font ROM and emits a 1-bit pixel.
- Hsync, vsync and video_on are delay-matched to the pixel.
- The aux word at a selectable address is shown inverted and blinking, so the current PC word can be highlighted.

Parameters:
- DATA_WIDTH, 16, aux word width; four hex digits per word.
- AUX_ADDRESS_WIDTH, 5, aux RAM address width.
- COORD_WIDTH, 10, pixel_x_in/pixel_y_in width.
- ROWS_PER_COLUMN, 10, words per displayed column; equals CPU_ELEMENTS = MEMORY_ELEMENTS.
- COLUMNS, 3, displayed columns: CPU, instruction, data.
- TEXT_X0, 64, left pixel of the text area.
- TEXT_Y0, 64, top pixel of the text area.
- BLINK_FRAMES, 30, frames per highlight blink half-period.

Ports:
- clock_in  in  1  pixel clock
- reset_in  in  1  synchronous, active-high reset
- pixel_x_in  in  COORD_WIDTH  current column from the VGA timing generator
- pixel_y_in  in  COORD_WIDTH  current line from the VGA timing generator
- video_on_in  in  1  visible-area flag
- h_sync_in  in  1  horizontal sync, active low
- v_sync_in  in  1  vertical sync, active low
- aux_data_in  in  DATA_WIDTH  aux RAM read data; valid 1 cycle after the address
- font_row_in  in  8  font ROM row bits; bit 7 is the leftmost pixel; valid 1 cycle after the address
- highlight_address_in  in  AUX_ADDRESS_WIDTH  aux address of the word to highlight
- highlight_enable_in  in  1  enables highlighting
- aux_raddress_out  out  AUX_ADDRESS_WIDTH  aux RAM read address
- font_address_out  out  8  {hex nibble[3:0], glyph row[3:0]}
- pixel_out  out  1  foreground pixel
- video_on_out  out  1  video_on_in delayed by 3 cycles
- h_sync_out  out  1  h_sync_in delayed by 3 cycles
- v_sync_out  out  1  v_sync_in delayed by 3 cycles

Behaviour:
- Single clock domain (clock_in). reset_in is synchronous and active-high.
- Reset values:
  - aux_raddress_out=0, font_address_out=0, pixel_out=0, video_on_out=0.
  - h_sync_out=1, v_sync_out=1.
  - All pipeline valid/inside flags=0, blink counter=0, blink phase=0.
- Reset asserted mid-line: the next edge applies the reset values. The 3-stage pipe then refills; no stale pixel may appear after reset is released.
- Geometry (stage 0, combinational on the inputs):
  - rx = pixel_x_in - TEXT_X0, ry = pixel_y_in - TEXT_Y0; both computed COORD_WIDTH+1 wide so that negative results mean "outside".
  - Character cell is 8x16 px; column pitch is 64 px (8 cells).
  - col = rx[..:6], digit = rx[5:3], bit = rx[2:0], row = ry[..:4], glyph_row = ry[3:0].
  - inside = rx>=0 && ry>=0 && col<COLUMNS && row<ROWS_PER_COLUMN && digit<4.
- Cycle 1 (register): aux_raddress_out = col*ROWS_PER_COLUMN + row, truncated to AUX_ADDRESS_WIDTH; col*10 is computed as (col<<3)+(col<<1). The address is forced to 0 when not inside. digit, glyph_row, bit, inside, hl_match = (address==highlight_address_in), the syncs and video_on are piped alongside.
- Cycle 2 (register): nibble = aux_data_in[15-4*digit -: 4], so digit 0 is the most significant nibble. font_address_out = {nibble, glyph_row}. bit, inside, hl_match and the syncs are piped.
- Cycle 3 (register):
  - fg = font_row_in[7-bit].
  - hl = hl_match && highlight_enable_in && blink_phase.
  - pixel_out = video_on && inside && (fg XOR hl).
  - When video_on is low, pixel_out is 0 regardless of the other terms.
- Latency: exactly 3 clocks from the pixel inputs to pixel_out/video_on_out/h_sync_out/v_sync_out. Throughput is one pixel per clock with no stalls.
- Blink counter:
  - Counts falling edges of the stage-0 v_sync_in, detected with a registered previous value.
  - On reaching BLINK_FRAMES-1 it wraps to 0 and blink_phase toggles.
  - When highlight_enable_in=0 the counter keeps running, but hl is 0.
- Boundary cases:
  - Pixel left of or above the origin (negative rx/ry) → outside.
  - Spacer digits 4..7, col>=COLUMNS, row>=ROWS_PER_COLUMN → outside; aux address 0; pixel 0.
  - highlight_address_in >= COLUMNS*ROWS_PER_COLUMN never matches any visible cell.
  - A v_sync falling edge on the same cycle as reset → reset wins; the counter stays 0.

Test Plan:
- Reset, then pixel (64,64), video_on=1, aux[0]=0x1234 → cycle1 aux_raddress_out=0; cycle2 font_address_out=0x10; cycle3 pixel_out=font_row_in[7].
- Pixel (200,213), aux[29]=0xA5C3 → aux_raddress_out=29 (col 2, row 9); font_address_out=0x55 (digit 1 = 0x5, glyph row 5); pixel_out=font_row_in[7].
- Pixels (104,64) (digit 5), (256,64) (col 3), (63,64) and (64,224) (row 10) → aux_raddress_out=0, pixel_out=0 for every case.
- BLINK_FRAMES=2, highlight_enable_in=1, highlight_address_in=12, font_row_in=0x00 over cell (64+64,64+32):
  - pixel_out=1 only while blink_phase=1.
  - blink_phase toggles every 2nd v_sync falling edge.
  - pixel_out=0 everywhere once highlight_enable_in=0.
- Drive a repeating h_sync/v_sync/video_on pattern → the outputs equal the inputs delayed by exactly 3 clocks.
- Assert reset_in for 1 cycle mid-row → next cycle pixel_out=0, h_sync_out=1, v_sync_out=1, blink counter 0; correct pixels resume 3 cycles after release.

Source files
------------

// File: rtl/hex_text_renderer.sv
// Renders the aux snapshot RAM as a grid of hex words: 3-stage pipeline from
// pixel coordinate to 1-bit foreground pixel, with a blinking inverted highlight.
module hex_text_renderer #(
  parameter int DATA_WIDTH        = 16,
  parameter int AUX_ADDRESS_WIDTH = 5,
  parameter int COORD_WIDTH       = 10,
  parameter int ROWS_PER_COLUMN   = 10,
  parameter int COLUMNS           = 3,
  parameter int TEXT_X0           = 64,
  parameter int TEXT_Y0           = 64,
  parameter int BLINK_FRAMES      = 30
) (
  input  logic                         clock_in,
  input  logic                         reset_in,
  input  logic [COORD_WIDTH-1:0]       pixel_x_in,
  input  logic [COORD_WIDTH-1:0]       pixel_y_in,
  input  logic                         video_on_in,
  input  logic                         h_sync_in,
  input  logic                         v_sync_in,
  input  logic [DATA_WIDTH-1:0]        aux_data_in,
  input  logic [7:0]                   font_row_in,
  input  logic [AUX_ADDRESS_WIDTH-1:0] highlight_address_in,
  input  logic                         highlight_enable_in,
  output logic [AUX_ADDRESS_WIDTH-1:0] aux_raddress_out,
  output logic [7:0]                   font_address_out,
  output logic                         pixel_out,
  output logic                         video_on_out,
  output logic                         h_sync_out,
  output logic                         v_sync_out
);

  localparam int SW    = COORD_WIDTH + 1;
  localparam int CW    = COORD_WIDTH - 6;
  localparam int RW    = COORD_WIDTH - 4;
  localparam int AW    = AUX_ADDRESS_WIDTH;
  localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [CW-1:0]    COLS_L   = CW'(COLUMNS);
  localparam logic [RW-1:0]    ROWS_L   = RW'(ROWS_PER_COLUMN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

  // Stage 0: geometry. The extra MSB of rx/ry flags coordinates before the origin.
  logic [SW-1:0] rx, ry;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [AW-1:0] col_a, row_a, aux_raddress_d;
  logic          inside_d, hl_match_d;

  assign rx = {1'b0, pixel_x_in} - SW'(TEXT_X0);
  assign ry = {1'b0, pixel_y_in} - SW'(TEXT_Y0);

  always_comb begin
    col            = rx[COORD_WIDTH-1:6];
    row            = ry[COORD_WIDTH-1:4];
    inside_d       = !rx[SW-1] && !ry[SW-1] && (col < COLS_L) && (row < ROWS_L) && !rx[5];
    col_a          = AW'(col);
    row_a          = AW'(row);
    aux_raddress_d = '0;
    if (inside_d) aux_raddress_d = (col_a << 3) + (col_a << 1) + row_a;
    hl_match_d     = (aux_raddress_d == highlight_address_in);
  end

  // Stage 1 registers
  logic [AW-1:0] aux_raddress_q;
  logic [1:0]    digit1_q;
  logic [3:0]    glyph1_q;
  logic [2:0]    bit1_q;
  logic          inside1_q, hl1_q, hs1_q, vs1_q, vo1_q;

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      aux_raddress_q <= '0;
      digit1_q       <= '0;
      glyph1_q       <= '0;
      bit1_q         <= '0;
      inside1_q      <= 1'b0;
      hl1_q          <= 1'b0;
      hs1_q          <= 1'b1;
      vs1_q          <= 1'b1;
      vo1_q          <= 1'b0;
    end else begin
      aux_raddress_q <= aux_raddress_d;
      digit1_q       <= rx[4:3];
      glyph1_q       <= ry[3:0];
      bit1_q         <= rx[2:0];
      inside1_q      <= inside_d;
      hl1_q          <= hl_match_d;
      hs1_q          <= h_sync_in;
      vs1_q          <= v_sync_in;
      vo1_q          <= video_on_in;
    end
  end

  // Stage 2: digit 0 is the most significant nibble of the word.
  logic [3:0] nibble_d;
  logic [7:0] font_address_q;
  logic [2:0] bit2_q;
  logic       inside2_q, hl2_q, hs2_q, vs2_q, vo2_q;

  always_comb begin
    nibble_d = aux_data_in[(DATA_WIDTH - 1) - 4 * int'(digit1_q) -: 4];
  end

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      font_address_q <= '0;
      bit2_q         <= '0;
      inside2_q      <= 1'b0;
      hl2_q          <= 1'b0;
      hs2_q          <= 1'b1;
      vs2_q          <= 1'b1;
      vo2_q          <= 1'b0;
    end else begin
      font_address_q <= {nibble_d, glyph1_q};
      bit2_q         <= bit1_q;
      inside2_q      <= inside1_q;
      hl2_q          <= hl1_q;
      hs2_q          <= hs1_q;
      vs2_q          <= vs1_q;
      vo2_q          <= vo1_q;
    end
  end

  // Blink timer: counts v_sync falling edges seen at the pipeline input.
  logic             vs_prev_q;
  logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
  logic             blink_phase_q, blink_phase_d;

  always_comb begin
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (vs_prev_q && !v_sync_in) begin
      if (blink_cnt_q == CNT_LAST) begin
        blink_cnt_d   = '0;
        blink_phase_d = !blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      vs_prev_q     <= 1'b1;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else begin
      vs_prev_q     <= v_sync_in;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end

  // Stage 3: glyph bit, optionally inverted for the highlighted word.
  logic fg_d, hl_d, pixel_d;
  logic pixel_q, hs3_q, vs3_q, vo3_q;

  always_comb begin
    fg_d    = font_row_in[3'd7 - bit2_q];
    hl_d    = hl2_q && highlight_enable_in && blink_phase_q;
    pixel_d = vo2_q && inside2_q && (fg_d ^ hl_d);
  end

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      pixel_q <= 1'b0;
      hs3_q   <= 1'b1;
      vs3_q   <= 1'b1;
      vo3_q   <= 1'b0;
    end else begin
      pixel_q <= pixel_d;
      hs3_q   <= hs2_q;
      vs3_q   <= vs2_q;
      vo3_q   <= vo2_q;
    end
  end

  assign aux_raddress_out = aux_raddress_q;
  assign font_address_out = font_address_q;
  assign pixel_out        = pixel_q;
  assign video_on_out     = vo3_q;
  assign h_sync_out       = hs3_q;
  assign v_sync_out       = vs3_q;

endmodule
